reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sequences reset release for the fabric once the synchronized fabric reset deasserts. It releases memory, peripheral and core reset domains in a fixed order, with programmable gaps between them and a memory-ready handshake. It also services software-requested warm resets. It sits directly downstream of the PolarFire fabric reset synchronizer: that block's FABRIC_RESET_N, inverted, drives RST here.

## Interface
Parameters:
- HOLD_CYCLES, 16: cycles all domains stay in reset after RST deasserts; legal range 1..2^CNT_W-1.
- STAGE_GAP, 8: cycles between consecutive domain releases; legal range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 1024: maximum wait for MEM_READY (watchdog build only); legal range 1..2^CNT_W-1.
- CNT_W, 11: width of the shared down-counter; must hold the largest of the three values above.

Ports:
- CLK, input, 1: fabric clock; the only clock.
- RST, input, 1: asynchronous, active-high reset; assertion is asynchronous, deassertion is already synchronized upstream.
- MEM_READY, input, 1: memory controller initialised; level, synchronous to CLK.
- SW_RST_REQ, input, 1: single-cycle warm-reset request pulse.
- MEM_RESET_N, output, 1: memory-domain reset, active-low.
- PERIPH_RESET_N, output, 1: peripheral-domain reset, active-low.
- CORE_RESET_N, output, 1: core-domain reset, active-low.
- SEQ_DONE, output, 1: high only while in RUN.
- SEQ_FAULT, output, 1: sticky; set by a MEM_READY timeout.

## Operation
- States: HOLD, REL_MEM, WAIT_MEM, GAP_PERIPH, GAP_CORE, RUN, WARM.
- Reset values:
  - State is HOLD.
  - MEM_RESET_N, PERIPH_RESET_N and CORE_RESET_N are 0.
  - SEQ_DONE and SEQ_FAULT are 0.
  - Counter is loaded with HOLD_CYCLES-1.
- HOLD: counter decrements each cycle. At zero, go to REL_MEM.
- REL_MEM: MEM_RESET_N goes to 1. Go to WAIT_MEM.
- WAIT_MEM:
  - When MEM_READY=1, load the counter with STAGE_GAP-1 and go to GAP_PERIPH.
  - MEM_READY is sampled starting the cycle after MEM_RESET_N rises.
- GAP_PERIPH: counter decrements. At zero, PERIPH_RESET_N goes to 1, the counter is reloaded with STAGE_GAP-1, and the state goes to GAP_CORE.
- GAP_CORE: counter decrements. At zero, CORE_RESET_N goes to 1 and the state goes to RUN.
- RUN:
  - SEQ_DONE=1.
  - SW_RST_REQ=1 sends the block to WARM.
- WARM:
  - In the cycle WARM is entered, CORE_RESET_N and PERIPH_RESET_N go to 0 and SEQ_DONE goes to 0.
  - MEM_RESET_N stays 1.
  - Counter is loaded with HOLD_CYCLES-1 and decrements.
  - At zero, load STAGE_GAP-1 and go to GAP_PERIPH; memory is not re-initialised.
- SW_RST_REQ outside RUN is ignored and not queued.
- Release order: a reset output, once released, stays released until RST or WARM. Only WARM re-asserts resets, and only core and peripheral.
- RST assertion at any time forces all outputs low in the same instant, asynchronously, and clears SEQ_FAULT.

## Timing
- Time is counted in CLK edges after the first edge at which RST is sampled low.
- MEM_RESET_N rises HOLD_CYCLES+1 edges after that edge.
- With MEM_READY already high:
  - PERIPH_RESET_N rises STAGE_GAP+1 edges after MEM_RESET_N.
  - CORE_RESET_N rises STAGE_GAP edges after PERIPH_RESET_N.
  - SEQ_DONE rises 1 edge after CORE_RESET_N.
- Warm reset: resets drop 1 edge after the SW_RST_REQ edge. PERIPH_RESET_N rises HOLD_CYCLES+STAGE_GAP edges after that.
- Outputs are registered, with no combinational path from any input. The only exception is the asynchronous RST path.

## Configuration
- RST_SEQ_WDT_EN defined:
  - WAIT_MEM loads the counter with TIMEOUT_CYCLES-1 on entry.
  - If the counter reaches zero with MEM_READY still 0, SEQ_FAULT is set and sticky.
  - The sequence then proceeds to GAP_PERIPH as if MEM_READY had arrived.
  - MEM_READY=1 on the same cycle as the zero count takes priority: no fault.
- RST_SEQ_WDT_EN undefined:
  - WAIT_MEM waits indefinitely.
  - SEQ_FAULT is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Power-up: RST released, MEM_READY=1, HOLD_CYCLES=16, STAGE_GAP=8 -> MEM_RESET_N rises at edge 17, PERIPH_RESET_N at 26, CORE_RESET_N at 34, SEQ_DONE at 35.
- Delayed memory: MEM_READY rises 100 cycles after MEM_RESET_N -> PERIPH_RESET_N rises exactly STAGE_GAP+1 edges after MEM_READY; SEQ_FAULT stays 0.
- Warm reset: SW_RST_REQ pulse in RUN -> CORE_RESET_N, PERIPH_RESET_N and SEQ_DONE drop next edge; MEM_RESET_N stays 1; full re-release follows. Pulse during GAP_CORE -> ignored.
- Mid-sequence RST: assert RST in GAP_PERIPH, between edges -> all outputs 0 immediately; on release, the sequence restarts from HOLD.
- Watchdog (RST_SEQ_WDT_EN, TIMEOUT_CYCLES=1024): MEM_READY held 0 -> SEQ_FAULT=1 after 1024 WAIT_MEM cycles, sequence completes, SEQ_FAULT remains 1 until RST.
- Watchdog boundary: MEM_READY rises on the zero-count cycle -> SEQ_FAULT stays 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release: memory, then peripheral, then core, with a memory-ready handshake and warm reset.
// Define RST_SEQ_WDT_EN to add the MEM_READY watchdog and the sticky SEQ_FAULT flag.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic CLK,
    input  logic RST,
    input  logic MEM_READY,
    input  logic SW_RST_REQ,
    output logic MEM_RESET_N,
    output logic PERIPH_RESET_N,
    output logic CORE_RESET_N,
    output logic SEQ_DONE,
    output logic SEQ_FAULT
);

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_REL_MEM    = 3'd1,
        ST_WAIT_MEM   = 3'd2,
        ST_GAP_PERIPH = 3'd3,
        ST_GAP_CORE   = 3'd4,
        ST_RUN        = 3'd5,
        ST_WARM       = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(STAGE_GAP - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             mem_r, mem_s;
    logic             periph_r, periph_s;
    logic             core_r, core_s;
    logic             done_r, done_s;
    logic             fault_r, fault_s;
    logic             cnt_zero_s;

    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

    // State, counter and output registers; RST clears everything asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= ST_HOLD;
            cnt_r    <= HOLD_LOAD;
            mem_r    <= 1'b0;
            periph_r <= 1'b0;
            core_r   <= 1'b0;
            done_r   <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            mem_r    <= mem_s;
            periph_r <= periph_s;
            core_r   <= core_s;
            done_r   <= done_s;
            fault_r  <= fault_s;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        mem_s    = mem_r;
        periph_s = periph_r;
        core_s   = core_r;
        done_s   = 1'b0;
        fault_s  = fault_r;
        case (state_r)
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    state_s = ST_REL_MEM;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_REL_MEM: begin
                // The timeout load is harmless when the watchdog is compiled out.
                mem_s   = 1'b1;
                cnt_s   = TIMEOUT_LOAD;
                state_s = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (MEM_READY) begin
                    cnt_s   = GAP_LOAD;
                    state_s = ST_GAP_PERIPH;
                end else begin
`ifdef RST_SEQ_WDT_EN
                    if (cnt_zero_s) begin
                        fault_s = 1'b1;
                        cnt_s   = GAP_LOAD;
                        state_s = ST_GAP_PERIPH;
                    end else begin
                        cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_s = ST_WAIT_MEM;
`endif
                end
            end
            ST_GAP_PERIPH: begin
                if (cnt_zero_s) begin
                    periph_s = 1'b1;
                    cnt_s    = GAP_LOAD;
                    state_s  = ST_GAP_CORE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP_CORE: begin
                if (cnt_zero_s) begin
                    core_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (SW_RST_REQ) begin
                    periph_s = 1'b0;
                    core_s   = 1'b0;
                    cnt_s    = HOLD_LOAD;
                    state_s  = ST_WARM;
                end else begin
                    done_s = 1'b1;
                end
            end
            ST_WARM: begin
                // Memory stays out of reset, so the sequence resumes at the peripheral gap.
                if (cnt_zero_s) begin
                    cnt_s   = GAP_LOAD;
                    state_s = ST_GAP_PERIPH;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s  = ST_HOLD;
                cnt_s    = HOLD_LOAD;
                mem_s    = 1'b0;
                periph_s = 1'b0;
                core_s   = 1'b0;
            end
        endcase
    end

    assign MEM_RESET_N    = mem_r;
    assign PERIPH_RESET_N = periph_r;
    assign CORE_RESET_N   = core_r;
    assign SEQ_DONE       = done_r;
`ifdef RST_SEQ_WDT_EN
    assign SEQ_FAULT      = fault_r;
`else
    assign SEQ_FAULT      = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up timing, delayed memory, warm reset, mid-sequence RST
// and, when RST_SEQ_WDT_EN is defined, the MEM_READY watchdog.
module tb_reset_sequencer;

    logic CLK;
    logic RST;
    logic MEM_READY;
    logic SW_RST_REQ;
    logic MEM_RESET_N;
    logic PERIPH_RESET_N;
    logic CORE_RESET_N;
    logic SEQ_DONE;
    logic SEQ_FAULT;

    int total;
    int bad;

    reset_sequencer #(
        .HOLD_CYCLES    (16),
        .STAGE_GAP      (8),
        .TIMEOUT_CYCLES (1024),
        .CNT_W          (11)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .MEM_READY      (MEM_READY),
        .SW_RST_REQ     (SW_RST_REQ),
        .MEM_RESET_N    (MEM_RESET_N),
        .PERIPH_RESET_N (PERIPH_RESET_N),
        .CORE_RESET_N   (CORE_RESET_N),
        .SEQ_DONE       (SEQ_DONE),
        .SEQ_FAULT      (SEQ_FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; MEM_READY = 1'b1; SW_RST_REQ = 1'b0;
        #1;
        total++;
        if ({MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE, SEQ_FAULT} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_t0: got %b expected 00000",
                     {MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE, SEQ_FAULT});
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE, SEQ_FAULT} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_held: got %b expected 00000",
                     {MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE, SEQ_FAULT});
        end
    endtask

    // Every edge 1..40 after release: MEM at 17, PERIPH at 26, CORE at 34, DONE at 35.
    task automatic test_power_up();
        logic [3:0] exp;
        MEM_READY = 1'b1;
        RST = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            exp = {(n >= 17), (n >= 26), (n >= 34), (n >= 35)};
            total++;
            if ({MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE} !== exp) begin
                bad++;
                $display("FAIL power_up edge %0d: got %b expected %b", n,
                         {MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE}, exp);
            end
        end
        total++;
        if (SEQ_FAULT !== 1'b0) begin
            bad++;
            $display("FAIL power_up_fault: got %b expected 0", SEQ_FAULT);
        end
    endtask

    // Warm reset from RUN, plus a request during GAP_CORE that must be ignored.
    task automatic test_warm();
        logic [3:0] exp;
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        total++;
        if ({MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE} !== 4'b1000) begin
            bad++;
            $display("FAIL warm_drop: got %b expected 1000",
                     {MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE});
        end
        for (int k = 1; k <= 38; k++) begin
            if (k == 27) SW_RST_REQ = 1'b1;
            tick();
            SW_RST_REQ = 1'b0;
            exp = {1'b1, (k >= 24), (k >= 32), (k >= 33)};
            total++;
            if ({MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE} !== exp) begin
                bad++;
                $display("FAIL warm edge %0d: got %b expected %b", k,
                         {MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE}, exp);
            end
        end
    endtask

    // Assert RST between edges inside GAP_PERIPH, then check a clean restart from HOLD.
    task automatic test_mid_rst();
        RST = 1'b1;
        tick();
        MEM_READY = 1'b1;
        RST = 1'b0;
        for (int n = 1; n <= 22; n++) tick();
        total++;
        if ({MEM_RESET_N, PERIPH_RESET_N} !== 2'b10) begin
            bad++;
            $display("FAIL mid_rst_pre: got %b expected 10", {MEM_RESET_N, PERIPH_RESET_N});
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if ({MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE, SEQ_FAULT} !== 5'b00000) begin
            bad++;
            $display("FAIL mid_rst_async: got %b expected 00000",
                     {MEM_RESET_N, PERIPH_RESET_N, CORE_RESET_N, SEQ_DONE, SEQ_FAULT});
        end
        tick();
        RST = 1'b0;
        for (int n = 1; n <= 16; n++) tick();
        total++;
        if (MEM_RESET_N !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_edge16: got %b expected 0", MEM_RESET_N);
        end
        tick();
        total++;
        if (MEM_RESET_N !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst_edge17: got %b expected 1", MEM_RESET_N);
        end
    endtask

    // MEM_READY arrives 100 cycles after MEM_RESET_N; PERIPH follows 9 edges later.
    task automatic test_delayed_mem();
        RST = 1'b1;
        MEM_READY = 1'b0;
        tick();
        RST = 1'b0;
        for (int n = 1; n <= 17; n++) tick();
        total++;
        if (MEM_RESET_N !== 1'b1) begin
            bad++;
            $display("FAIL delayed_mem_up: got %b expected 1", MEM_RESET_N);
        end
        for (int n = 1; n <= 100; n++) tick();
        total++;
        if ({PERIPH_RESET_N, SEQ_FAULT} !== 2'b00) begin
            bad++;
            $display("FAIL delayed_mem_wait: got %b expected 00", {PERIPH_RESET_N, SEQ_FAULT});
        end
        MEM_READY = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++;
            if (PERIPH_RESET_N !== (k == 9)) begin
                bad++;
                $display("FAIL delayed_mem edge %0d: got %b expected %b", k, PERIPH_RESET_N, (k == 9));
            end
        end
        total++;
        if (SEQ_FAULT !== 1'b0) begin
            bad++;
            $display("FAIL delayed_mem_fault: got %b expected 0", SEQ_FAULT);
        end
    endtask

`ifdef RST_SEQ_WDT_EN
    // Timeout after 1024 WAIT_MEM cycles, or MEM_READY exactly on the zero-count cycle.
    task automatic test_watchdog(input logic ready_at_zero);
        logic exp_fault;
        exp_fault = ~ready_at_zero;
        RST = 1'b1;
        MEM_READY = 1'b0;
        tick();
        RST = 1'b0;
        for (int n = 1; n <= 17; n++) tick();
        for (int n = 1; n <= 1023; n++) tick();
        total++;
        if ({SEQ_FAULT, PERIPH_RESET_N} !== 2'b00) begin
            bad++;
            $display("FAIL wdt_before: got %b expected 00", {SEQ_FAULT, PERIPH_RESET_N});
        end
        if (ready_at_zero) MEM_READY = 1'b1;
        tick();
        total++;
        if (SEQ_FAULT !== exp_fault) begin
            bad++;
            $display("FAIL wdt_zero: got %b expected %b", SEQ_FAULT, exp_fault);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if ({SEQ_FAULT, PERIPH_RESET_N, CORE_RESET_N} !== {exp_fault, (k >= 8), (k >= 16)}) begin
                bad++;
                $display("FAIL wdt_after edge %0d: got %b expected %b", k,
                         {SEQ_FAULT, PERIPH_RESET_N, CORE_RESET_N}, {exp_fault, (k >= 8), (k >= 16)});
            end
        end
        RST = 1'b1;
        #1;
        total++;
        if (SEQ_FAULT !== 1'b0) begin
            bad++;
            $display("FAIL wdt_clear: got %b expected 0", SEQ_FAULT);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_power_up();
        test_warm();
        test_mid_rst();
        test_delayed_mem();
`ifdef RST_SEQ_WDT_EN
        test_watchdog(1'b0);
        test_watchdog(1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
